// File: rtl/uart_imem_loader.sv
// Purpose: receives an 8N1 UART packet (16-bit word count + LE 32-bit words) and writes it into instruction memory.
// Latency: imem_we asserts 1 cycle after the byte_valid of each word's 4th byte; done pulses the cycle after the last write.
// Backpressure: none; the serial line cannot be stalled, and bytes arriving while not armed are dropped.
module uart_imem_loader #(
   parameter int CLKS_PER_BIT = 100,
   parameter int ADDR_WIDTH   = 14,
   parameter int DEPTH        = 16384
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  load_en,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  cpu_hold
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {L_IDLE, L_CNT0, L_CNT1, L_DATA, L_WRITE} ld_state_t;

   // ---------------- receiver ----------------
   logic            rx_s1, rx_s2;
   rx_state_t       r_state, r_next;
   logic [CW-1:0]   clk_cnt, cnt_next;
   logic [2:0]      bit_idx, bit_next;
   logic [7:0]      rx_byte, sh_next;
   logic            byte_valid, bv_next;
   logic            frame_err, fe_next;

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   // Receiver next state: mid-bit sampling relative to the detected start edge.
   always_comb begin
      r_next   = r_state;
      cnt_next = clk_cnt + 1'b1;
      bit_next = bit_idx;
      sh_next  = rx_byte;
      bv_next  = 1'b0;
      fe_next  = 1'b0;
      case (r_state)
         R_IDLE: begin
            cnt_next = '0;
            if (!rx_s2) r_next = R_START;
         end
         R_START: begin
            if (clk_cnt == HALF_LAST) begin
               cnt_next = '0;
               bit_next = 3'd0;
               r_next   = rx_s2 ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               cnt_next = '0;
               sh_next  = {rx_s2, rx_byte[7:1]};
               if (bit_idx == 3'd7) r_next = R_STOP;
               else                 bit_next = bit_idx + 3'd1;
            end
         end
         R_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               cnt_next = '0;
               r_next   = R_IDLE;
               if (rx_s2) bv_next = 1'b1;
               else       fe_next = 1'b1;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Receiver state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= R_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= 3'd0;
         rx_byte    <= 8'd0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_state    <= r_next;
         clk_cnt    <= cnt_next;
         bit_idx    <= bit_next;
         rx_byte    <= sh_next;
         byte_valid <= bv_next;
         frame_err  <= fe_next;
      end
   end

   // ---------------- loader ----------------
   ld_state_t             l_state, l_next;
   logic                  load_en_q;
   logic                  arm_edge, do_arm, set_done, set_err;
   logic [15:0]           count, new_count, word_cnt, word_cnt_inc;
   logic [1:0]            byte_idx;
   logic [23:0]           word_lo;
   logic [ADDR_WIDTH-1:0] addr;

   assign arm_edge     = load_en & ~load_en_q;
   assign new_count    = {rx_byte, count[7:0]};
   assign word_cnt_inc = word_cnt + 16'd1;
   assign cpu_hold     = busy;

   // Loader next state; a framing error mid-load overrides everything and ends the load.
   always_comb begin
      l_next   = l_state;
      do_arm   = 1'b0;
      set_done = 1'b0;
      set_err  = 1'b0;
      case (l_state)
         L_IDLE: begin
            if (arm_edge) begin
               l_next = L_CNT0;
               do_arm = 1'b1;
            end
         end
         L_CNT0: if (byte_valid) l_next = L_CNT1;
         L_CNT1: begin
            if (byte_valid) begin
               if (new_count == 16'd0) begin
                  l_next   = L_IDLE;
                  set_done = 1'b1;
               end else if ({1'b0, new_count} > 17'(DEPTH)) begin
                  l_next  = L_IDLE;
                  set_err = 1'b1;
               end else begin
                  l_next = L_DATA;
               end
            end
         end
         L_DATA: if (byte_valid && byte_idx == 2'd3) l_next = L_WRITE;
         L_WRITE: begin
            if (word_cnt_inc == count) begin
               l_next   = L_IDLE;
               set_done = 1'b1;
            end else begin
               l_next = L_DATA;
            end
         end
         default: l_next = L_IDLE;
      endcase
      if (frame_err && l_state != L_IDLE) begin
         l_next   = L_IDLE;
         set_err  = 1'b1;
         set_done = 1'b0;
      end
   end

   // Loader datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         l_state    <= L_IDLE;
         load_en_q  <= 1'b0;
         count      <= 16'd0;
         word_cnt   <= 16'd0;
         byte_idx   <= 2'd0;
         word_lo    <= 24'd0;
         addr       <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         l_state   <= l_next;
         load_en_q <= load_en;
         done      <= set_done;
         imem_we   <= 1'b0;
         if (do_arm) begin
            err      <= 1'b0;
            busy     <= 1'b1;
            addr     <= '0;
            byte_idx <= 2'd0;
            word_cnt <= 16'd0;
         end
         if (set_err) err <= 1'b1;
         if (set_done || set_err) busy <= 1'b0;
         if (byte_valid) begin
            case (l_state)
               L_CNT0: count[7:0]  <= rx_byte;
               L_CNT1: count[15:8] <= rx_byte;
               L_DATA: begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_lo[7:0]   <= rx_byte;
                     2'd1: word_lo[15:8]  <= rx_byte;
                     2'd2: word_lo[23:16] <= rx_byte;
                     default: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= {rx_byte, word_lo};
                     end
                  endcase
               end
               default: ;
            endcase
         end
         if (l_state == L_WRITE) begin
            addr     <= addr + 1'b1;
            word_cnt <= word_cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: packets driven bit-by-bit on rx, writes collected from the memory port.
// Latency: checks are made a few cycles after the last byte of each scenario, within bounded waits.
// Backpressure: none on the DUT; the bench paces bytes at CLKS_PER_BIT cycles per bit.
module tb_uart_imem_loader;
   localparam int CPB = 4;
   localparam int AW  = 4;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx = 1'b1;
   logic          load_en = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy, done, err, cpu_hold;

   int n_cmp = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int clash_cnt = 0;
   int bv_cnt = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst), .rx(rx), .load_en(load_en),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
      if (done) done_cnt++;
      if (done && err) clash_cnt++;
      if (dut.byte_valid) bv_cnt++;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(posedge clk); #1 rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rx = stop_bit;
      repeat (CPB) @(posedge clk);
      #1 rx = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic arm();
      @(posedge clk); #1 load_en = 1'b1;
      @(posedge clk); #1 load_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b0, {AW{1'b0}}, 32'd0}) begin
         n_fail++; $display("FAIL reset_wport got %b/%h/%h want 0/0/0", imem_we, imem_addr, imem_wdata);
      end
      n_cmp++;
      if ({busy, done, err, cpu_hold} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_status got %b want 0000", {busy, done, err, cpu_hold});
      end
      n_cmp++;
      rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_two_words();
      int base = wr_addr.size();
      int d0 = done_cnt;
      logic [7:0] pkt [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      arm();
      if ({busy, cpu_hold} !== 2'b11) begin
         n_fail++; $display("FAIL arm_busy got %b want 11", {busy, cpu_hold});
      end
      n_cmp++;
      foreach (pkt[i]) send_byte(pkt[i], 1'b1);
      for (int i = 0; i < 60 && done_cnt == d0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      if (wr_addr.size() - base !== 2) begin
         n_fail++; $display("FAIL two_words_count got %0d want 2", wr_addr.size() - base);
      end
      n_cmp++;
      if (wr_addr.size() - base >= 2) begin
         if (wr_addr[base] !== 4'd0 || wr_data[base] !== 32'h12345678) begin
            n_fail++; $display("FAIL word0 got %h@%h want 12345678@0", wr_data[base], wr_addr[base]);
         end
         n_cmp++;
         if (wr_addr[base+1] !== 4'd1 || wr_data[base+1] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word1 got %h@%h want deadbeef@1", wr_data[base+1], wr_addr[base+1]);
         end
         n_cmp++;
      end
      if (done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL two_words_done got %0d pulses want 1", done_cnt - d0);
      end
      n_cmp++;
      if ({busy, cpu_hold, err} !== 3'b000) begin
         n_fail++; $display("FAIL two_words_end got busy/hold/err %b want 000", {busy, cpu_hold, err});
      end
      n_cmp++;
   endtask

   task automatic test_zero_count();
      int base = wr_addr.size();
      int d0 = done_cnt;
      arm();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 20 && done_cnt == d0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      if (done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL zero_done got %0d pulses want 1", done_cnt - d0);
      end
      n_cmp++;
      if (wr_addr.size() != base || err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_state got writes=%0d err=%b busy=%b want 0/0/0", wr_addr.size() - base, err, busy);
      end
      n_cmp++;
   endtask

   task automatic test_over_depth();
      int base = wr_addr.size();
      int d0 = done_cnt;
      arm();
      send_byte(8'h11, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      if ({err, busy} !== 2'b10) begin
         n_fail++; $display("FAIL over_depth got err/busy %b want 10", {err, busy});
      end
      n_cmp++;
      if (wr_addr.size() != base || done_cnt != d0) begin
         n_fail++; $display("FAIL over_depth_quiet got writes=%0d done=%0d want 0/0", wr_addr.size() - base, done_cnt - d0);
      end
      n_cmp++;
      arm();
      #1;
      if ({err, busy} !== 2'b01) begin
         n_fail++; $display("FAIL rearm_clear got err/busy %b want 01", {err, busy});
      end
      n_cmp++;
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (5) @(posedge clk);
   endtask

   task automatic test_framing();
      int base = wr_addr.size();
      int d0 = done_cnt;
      arm();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h78, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      if ({err, busy} !== 2'b10) begin
         n_fail++; $display("FAIL framing got err/busy %b want 10", {err, busy});
      end
      n_cmp++;
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      if (wr_addr.size() != base || done_cnt != d0 || err !== 1'b1) begin
         n_fail++; $display("FAIL framing_after got writes=%0d done=%0d err=%b want 0/0/1", wr_addr.size() - base, done_cnt - d0, err);
      end
      n_cmp++;
   endtask

   task automatic test_glitch_and_unarmed();
      int base = wr_addr.size();
      int bv0 = bv_cnt;
      logic [7:0] pkt [6] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      @(posedge clk); #1 rx = 1'b0;
      @(posedge clk); #1 rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      if (bv_cnt != bv0 || busy !== 1'b0 || err !== 1'b1) begin
         n_fail++; $display("FAIL glitch got bytes=%0d busy=%b err=%b want 0/0/1", bv_cnt - bv0, busy, err);
      end
      n_cmp++;
      foreach (pkt[i]) send_byte(pkt[i], 1'b1);
      repeat (5) @(posedge clk);
      #1;
      if (bv_cnt - bv0 !== 6) begin
         n_fail++; $display("FAIL unarmed_rx got %0d bytes want 6", bv_cnt - bv0);
      end
      n_cmp++;
      if (wr_addr.size() != base || busy !== 1'b0) begin
         n_fail++; $display("FAIL unarmed_writes got writes=%0d busy=%b want 0/0", wr_addr.size() - base, busy);
      end
      n_cmp++;
   endtask

   task automatic test_reset_midload();
      int base = wr_addr.size();
      int d0 = done_cnt;
      logic [7:0] pkt [8] = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA, 8'hBB};
      arm();
      foreach (pkt[i]) send_byte(pkt[i], 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      if ({imem_we, imem_addr, imem_wdata, busy, done, err, cpu_hold} !== '0) begin
         n_fail++; $display("FAIL midload_reset got we=%b addr=%h data=%h status=%b want all 0",
                            imem_we, imem_addr, imem_wdata, {busy, done, err, cpu_hold});
      end
      n_cmp++;
      rst = 1'b1;
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      if (wr_addr.size() - base !== 1) begin
         n_fail++; $display("FAIL midload_writes got %0d want 1", wr_addr.size() - base);
      end else begin
         if (wr_addr[base] !== 4'd0 || wr_data[base] !== 32'h11223344) begin
            n_fail++; $display("FAIL midload_word got %h@%h want 11223344@0", wr_data[base], wr_addr[base]);
         end
      end
      n_cmp++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midload_done got done=%0d busy=%b want 0/0", done_cnt - d0, busy);
      end
      n_cmp++;
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_zero_count();
      test_over_depth();
      test_framing();
      test_glitch_and_unarmed();
      test_reset_midload();
      if (clash_cnt !== 0) begin
         n_fail++; $display("FAIL done_err_clash got %0d cycles want 0", clash_cnt);
      end
      n_cmp++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
